mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single main-memory line port between the ICACHE refill path and the
//  DCACHE refill/write-back path of the multi-cycle core. Exactly one line
//  transaction is outstanding at a time.
//  Requests are latched at grant, forwarded to memory, and the response is routed
//  back to the owner. Sits between both caches and the memory model.
// PARAMETERS
//  PADDR_W      20   physical line address width (= params_pkg::PADDR_WIDTH)
//  LINE_W       CACHE_LINE_BYTES*8   line data width in bits
//  TIMEOUT_CYC  1024 cycles in WAIT before err_timeout is raised
// PORTS
//  clk            in   1        single clock, rising edge
//  rst_n          in   1        asynchronous, active-low reset
//  ic_req_valid   in   1        icache line read request; held until ic_resp_valid
//  ic_req_addr    in   PADDR_W  line-aligned read address
//  ic_resp_valid  out  1        one-cycle pulse: ic_resp_data valid
//  ic_resp_data   out  LINE_W   refill line
//  dc_req_valid   in   1        dcache request; held until dc_resp_valid
//  dc_req_we      in   1        1 = line write-back, 0 = line read
//  dc_req_addr    in   PADDR_W  line-aligned address
//  dc_req_wdata   in   LINE_W   write-back data (dc_req_we=1)
//  dc_resp_valid  out  1        one-cycle pulse: read data / write ack
//  dc_resp_data   out  LINE_W   refill line (don't-care on write ack)
//  mem_req_valid  out  1        request to memory
//  mem_req_ready  in   1        memory accepts when valid&&ready
//  mem_req_we     out  1        write enable
//  mem_req_addr   out  PADDR_W  address
//  mem_req_wdata  out  LINE_W   write data
//  mem_resp_valid in   1        memory response pulse (reads and write acks)
//  mem_resp_data  in   LINE_W   read data
//  busy           out  1        state != IDLE
//  err_timeout    out  1        sticky; set when WAIT exceeds TIMEOUT_CYC
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, owner=NONE, last_grant=IC.
//  All outputs 0, data regs 0, timeout counter 0, err_timeout 0.
//  FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   IDLE:  if any req_valid, grant and latch we/addr/wdata into req regs.
//          Set owner, go to ISSUE next cycle. No grant if neither valid.
//   ISSUE: mem_req_valid=1 from req regs; stay until mem_req_ready, then WAIT.
//          Outputs stay stable while stalled.
//   WAIT:  count cycles. On mem_resp_valid, latch mem_resp_data, go to RESP.
//          If count reaches TIMEOUT_CYC, set err_timeout. Keep waiting; no abort.
//   RESP:  pulse owner's resp_valid for exactly 1 cycle with latched data,
//          then go to IDLE. Counter clears.
//  Arbitration when both valid in IDLE: grant the side != last_grant (round robin).
//   last_grant updates on each grant. A single requester is granted immediately.
//  Latency, zero-wait memory (ready=1, resp the cycle after accept):
//   req_valid at cycle 0 -> mem_req_valid cycle 1 -> resp_valid cycle 4.
//  Requester holds req_valid through its resp pulse and may drop it the cycle after.
//   The arbiter samples requests only in IDLE. Changing addr/data after grant has
//   no effect. Requester re-asserting the cycle after resp is a new request.
//  Unsolicited mem_resp_valid outside WAIT is ignored: no pulse, no state change.
//  Reset mid-transaction: immediate return to IDLE, no resp pulse. A late memory
//   response after reset is ignored by the rule above.
//  Non-owner resp_valid is always 0. The two resp_valid outputs are never both 1.
// STRUCTURE
//  params_pkg gains arb_state_t enum {IDLE,ISSUE,WAIT,RESP} and owner_t {NONE,IC,DC}.
//  Also mem_req_t packed struct {we, addr, wdata}.
//  One sub-module: rr_arb2 (2-way round-robin picker, last_grant reg, 1-hot grant).
// TESTING
//  1 ic_req only, addr 0x01240, mem returns 0xA5.. -> one ic_resp pulse at cycle 4;
//    dc_resp_valid stays 0.
//  2 ic+dc valid same cycle after reset (last=IC) -> DC served first, then IC.
//    Next tie -> DC again.
//  3 dc write-back addr 0x00F80, mem_req_ready low 3 cycles -> mem_req_* held
//    stable; single dc_resp ack after mem_resp_valid.
//  4 memory never responds -> err_timeout=1 after 1024 WAIT cycles, stays 1.
//    Late response still routed to owner.
//  5 rst_n low during WAIT, then mem_resp_valid -> no resp pulse, busy=0, outputs 0.
//  6 spurious mem_resp_valid in IDLE -> ignored; random ic/dc traffic, 10k cycles
//    -> scoreboard data match, no starvation > 2 transactions.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Purpose: shared types and widths for the memory-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> RESP)
//   owner_t     : which cache owns the outstanding line transaction
//   mem_req_t   : one line request as presented to main memory
package mem_port_arbiter_pkg;

  localparam int unsigned PADDR_WIDTH      = 20;
  localparam int unsigned CACHE_LINE_BYTES = 16;
  localparam int unsigned LINE_WIDTH       = CACHE_LINE_BYTES * 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } arb_state_t;

  typedef enum logic [1:0] {
    OwnNone,
    OwnIc,
    OwnDc
  } owner_t;

  typedef struct packed {
    logic                    we;
    logic [PADDR_WIDTH-1:0]  addr;
    logic [LINE_WIDTH-1:0]   wdata;
  } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Purpose: 2-way round-robin picker for the memory-port arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : request vector, bit 0 = icache, bit 1 = dcache
//   take       : the grant is consumed this cycle; updates the last-grant record
//   gnt[1:0]   : one-hot grant (combinational), all-zero when req is zero
module mem_port_arbiter_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt
);

  // 0: icache was granted last (reset value), 1: dcache was granted last.
  logic last_dc;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_dc ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_dc <= 1'b0;
    end else if (take && (req != 2'b00)) begin
      last_dc <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares the single main-memory line port between the icache refill path and the
//   dcache refill/write-back path. One line transaction is outstanding at a time; the
//   request is latched at grant, issued to memory, and the response routed back to its owner.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   ic_req_valid/addr             : icache line read request (held until ic_resp_valid)
//   ic_resp_valid/data            : one-cycle refill pulse to the icache
//   dc_req_valid/we/addr/wdata    : dcache read or write-back request (held until dc_resp_valid)
//   dc_resp_valid/data            : one-cycle read data / write ack pulse to the dcache
//   mem_req_valid/ready/we/addr/wdata : request channel to memory
//   mem_resp_valid/data           : response pulse from memory
//   busy                          : a transaction is in flight
//   err_timeout                   : sticky, memory took TIMEOUT_CYC cycles or more to respond
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned PADDR_W     = PADDR_WIDTH,
  parameter int unsigned LINE_W      = LINE_WIDTH,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  input  logic [PADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [LINE_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [PADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_resp_valid,
  output logic [LINE_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [PADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              err_timeout
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  arb_state_t        state;
  owner_t            owner;
  logic [LINE_W-1:0] resp_data;
  logic [CntW-1:0]   wait_cnt;
  logic              take;
  logic [1:0]        gnt;

  // The response pulse leaves while the FSM is already back in IDLE and the owner still holds
  // req_valid during that pulse, so no grant may be taken in that cycle.
  assign take = (state == StIdle) && !ic_resp_valid && !dc_resp_valid;

  mem_port_arbiter_rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({dc_req_valid, ic_req_valid}),
    .take  (take),
    .gnt   (gnt)
  );

  assign ic_resp_data = resp_data;
  assign dc_resp_data = resp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= StIdle;
      owner         <= OwnNone;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      resp_data     <= '0;
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      wait_cnt      <= '0;
      busy          <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      ic_resp_valid <= 1'b0;
      dc_resp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (take && gnt[0]) begin
            owner         <= OwnIc;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= ic_req_addr;
            mem_req_wdata <= '0;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= StIssue;
          end else if (take && gnt[1]) begin
            owner         <= OwnDc;
            mem_req_we    <= dc_req_we;
            mem_req_addr  <= dc_req_addr;
            mem_req_wdata <= dc_req_wdata;
            mem_req_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= StIssue;
          end
        end
        StIssue: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            wait_cnt      <= '0;
            state         <= StWait;
          end
        end
        StWait: begin
          if (mem_resp_valid) begin
            resp_data <= mem_resp_data;
            state     <= StResp;
          end else if (wait_cnt != CntMax) begin
            // Saturating count; the error is flagged but the transaction keeps waiting.
            wait_cnt <= wait_cnt + CntW'(1);
            if (wait_cnt == CntLast) begin
              err_timeout <= 1'b1;
            end
          end
        end
        StResp: begin
          ic_resp_valid <= (owner == OwnIc);
          dc_resp_valid <= (owner == OwnDc);
          owner         <= OwnNone;
          wait_cnt      <= '0;
          busy          <= 1'b0;
          state         <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: self-checking bench for mem_port_arbiter. A directed per-cycle vector table covers
//   single-requester latency and round-robin ties; hand-written sequences cover memory stalls,
//   timeout, reset mid-transaction, spurious responses, then random traffic with a scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned AW = PADDR_WIDTH;
  localparam int unsigned LW = LINE_WIDTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ic_req_valid = 1'b0;
  logic [AW-1:0] ic_req_addr = '0;
  logic          ic_resp_valid;
  logic [LW-1:0] ic_resp_data;
  logic          dc_req_valid = 1'b0;
  logic          dc_req_we = 1'b0;
  logic [AW-1:0] dc_req_addr = '0;
  logic [LW-1:0] dc_req_wdata = '0;
  logic          dc_resp_valid;
  logic [LW-1:0] dc_resp_data;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b0;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_wdata;
  logic          mem_resp_valid;
  logic [LW-1:0] mem_resp_data;
  logic          busy;
  logic          err_timeout;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .dc_req_valid   (dc_req_valid),
    .dc_req_we      (dc_req_we),
    .dc_req_addr    (dc_req_addr),
    .dc_req_wdata   (dc_req_wdata),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_data   (dc_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .busy           (busy),
    .err_timeout    (err_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pat(input logic [AW-1:0] a);
    return {4{12'hA5A, a}};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    logic [31:0] r;
    r = $urandom();
    return {r[15:0], 4'h0};
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Memory model: logs every accepted request; when mem_auto is set it answers in the cycle
  // after the accept (reads return pat(addr)). man_v/man_d inject responses by hand.
  logic          mem_auto = 1'b1;
  logic          model_v = 1'b0;
  logic [LW-1:0] model_d = '0;
  logic          man_v = 1'b0;
  logic [LW-1:0] man_d = '0;
  mem_req_t      acc;
  int            acc_cnt = 0;

  assign mem_resp_valid = model_v | man_v;
  assign mem_resp_data  = man_v ? man_d : model_d;

  always begin
    @(negedge clk);
    if (mem_req_valid && mem_req_ready) begin
      acc.we    = mem_req_we;
      acc.addr  = mem_req_addr;
      acc.wdata = mem_req_wdata;
      acc_cnt++;
      if (mem_auto) begin
        model_d = mem_req_we ? '0 : pat(mem_req_addr);
        @(posedge clk);
        #1 model_v = 1'b1;
        @(posedge clk);
        #1 model_v = 1'b0;
      end
    end
  end

  typedef struct packed {
    logic          ic;
    logic          dc;
    logic          rdy;
    logic          mrv;
    logic          bsy;
    logic          icr;
    logic          dcr;
    logic          chk;
    logic [AW-1:0] addr;
  } vec_t;

  function automatic vec_t mkv(input logic ic, input logic dc, input logic rdy, input logic mrv,
                               input logic bsy, input logic icr, input logic dcr, input logic chk,
                               input logic [AW-1:0] addr);
    vec_t v;
    v.ic = ic; v.dc = dc; v.rdy = rdy; v.mrv = mrv; v.bsy = bsy;
    v.icr = icr; v.dcr = dcr; v.chk = chk; v.addr = addr;
    return v;
  endfunction

  localparam logic [AW-1:0] IA = 20'h01240;
  localparam logic [AW-1:0] DA = 20'h3A5C0;

  vec_t vecs[$];

  logic [LW-1:0] wb;
  logic [LW-1:0] late;
  int   acc0, pulses, other, ic_wait, dc_wait;
  logic seen, ic_done, dc_done;

  initial begin
    // ic alone: mem_req_valid at cycle 1, ic_resp pulse at cycle 4.
    vecs.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, '0));
    vecs.push_back(mkv(1, 0, 1, 1, 1, 0, 0, 1, IA));
    vecs.push_back(mkv(1, 0, 1, 0, 1, 0, 0, 0, '0));
    vecs.push_back(mkv(1, 0, 1, 0, 1, 0, 0, 0, '0));
    vecs.push_back(mkv(1, 0, 1, 0, 0, 1, 0, 0, '0));
    vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, '0));
    // Two ties in a row: last grant is IC each time, so DC goes first both times.
    for (int t = 0; t < 2; t++) begin
      vecs.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, '0));
      vecs.push_back(mkv(1, 1, 1, 1, 1, 0, 0, 1, DA));
      vecs.push_back(mkv(1, 1, 1, 0, 1, 0, 0, 0, '0));
      vecs.push_back(mkv(1, 1, 1, 0, 1, 0, 0, 0, '0));
      vecs.push_back(mkv(1, 1, 1, 0, 0, 0, 1, 0, '0));
      vecs.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, '0));
      vecs.push_back(mkv(1, 0, 1, 1, 1, 0, 0, 1, IA));
      vecs.push_back(mkv(1, 0, 1, 0, 1, 0, 0, 0, '0));
      vecs.push_back(mkv(1, 0, 1, 0, 1, 0, 0, 0, '0));
      vecs.push_back(mkv(1, 0, 1, 0, 0, 1, 0, 0, '0));
      vecs.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, '0));
    end

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst mem_req_valid", mem_req_valid, 0);
    check("rst mem_req_addr", mem_req_addr, 0);
    check("rst mem_req_wdata", mem_req_wdata, 0);
    check("rst ic_resp_valid", ic_resp_valid, 0);
    check("rst dc_resp_valid", dc_resp_valid, 0);
    check("rst resp_data", ic_resp_data, 0);
    check("rst err_timeout", err_timeout, 0);
    rst_n = 1'b1;

    // Directed vector table.
    ic_req_addr = IA;
    dc_req_addr = DA;
    dc_req_we   = 1'b0;
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      ic_req_valid  = vecs[i].ic;
      dc_req_valid  = vecs[i].dc;
      mem_req_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d mem_req_valid", i), mem_req_valid, vecs[i].mrv);
      check($sformatf("v%0d busy", i), busy, vecs[i].bsy);
      check($sformatf("v%0d ic_resp_valid", i), ic_resp_valid, vecs[i].icr);
      check($sformatf("v%0d dc_resp_valid", i), dc_resp_valid, vecs[i].dcr);
      if (vecs[i].chk) check($sformatf("v%0d mem_req_addr", i), mem_req_addr, vecs[i].addr);
      if (vecs[i].icr) check($sformatf("v%0d ic_resp_data", i), ic_resp_data, pat(IA));
      if (vecs[i].dcr) check($sformatf("v%0d dc_resp_data", i), dc_resp_data, pat(DA));
    end

    // dcache write-back with memory stalling 3 cycles; request changes after grant are ignored.
    wb = {4{32'hDEADBEEF}};
    acc0 = acc_cnt;
    @(posedge clk);
    #1;
    dc_req_valid = 1'b1; dc_req_we = 1'b1; dc_req_addr = 20'h00F80; dc_req_wdata = wb;
    mem_req_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk);
      #1;
      if (c == 2) begin
        dc_req_addr = 20'h11110; dc_req_wdata = '0; dc_req_we = 1'b0;
      end
      @(negedge clk);
      check($sformatf("wb stall%0d valid", c), mem_req_valid, 1);
      check($sformatf("wb stall%0d we", c), mem_req_we, 1);
      check($sformatf("wb stall%0d addr", c), mem_req_addr, 20'h00F80);
      check($sformatf("wb stall%0d wdata", c), mem_req_wdata, wb);
    end
    @(posedge clk);
    #1 mem_req_ready = 1'b1;
    pulses = 0; other = 0; seen = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      #1;
      if (seen) dc_req_valid = 1'b0;
      @(negedge clk);
      if (dc_resp_valid) begin pulses++; seen = 1'b1; end
      if (ic_resp_valid) other++;
    end
    check("wb ack pulses", pulses, 1);
    check("wb ic pulses", other, 0);
    check("wb accepts", acc_cnt - acc0, 1);
    check("wb mem we", acc.we, 1);
    check("wb mem addr", acc.addr, 20'h00F80);
    check("wb mem wdata", acc.wdata, wb);

    // Memory never answers: timeout flag after 1024 WAIT cycles, then a late answer still lands.
    mem_auto = 1'b0;
    dc_req_we = 1'b0;
    @(posedge clk);
    #1;
    ic_req_addr = 20'h0ABC0; ic_req_valid = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("to early err", err_timeout, 0);
    check("to early busy", busy, 1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("to err set", err_timeout, 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("to err sticky", err_timeout, 1);
    check("to still busy", busy, 1);
    late = {4{32'h0BADF00D}};
    @(posedge clk);
    #1;
    man_d = late; man_v = 1'b1;
    pulses = 0; other = 0; seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      man_v = 1'b0;
      if (seen) ic_req_valid = 1'b0;
      @(negedge clk);
      if (ic_resp_valid) begin
        pulses++; seen = 1'b1;
        check("to late data", ic_resp_data, late);
      end
      if (dc_resp_valid) other++;
    end
    check("to late pulses", pulses, 1);
    check("to late dc pulses", other, 0);
    check("to err after resp", err_timeout, 1);

    // Reset during WAIT, then a stale memory response.
    @(posedge clk);
    #1;
    ic_req_addr = 20'h05550; ic_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstw busy before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw busy", busy, 0);
    check("rstw mem_req_addr", mem_req_addr, 0);
    check("rstw err", err_timeout, 0);
    ic_req_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    man_d = pat(20'h05550); man_v = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 man_v = 1'b0;
      @(negedge clk);
      check($sformatf("rstw c%0d ic_resp", c), ic_resp_valid, 0);
      check($sformatf("rstw c%0d dc_resp", c), dc_resp_valid, 0);
      check($sformatf("rstw c%0d busy", c), busy, 0);
      check($sformatf("rstw c%0d mem_req_valid", c), mem_req_valid, 0);
    end
    check("rstw resp_data", ic_resp_data, 0);

    // Spurious response while idle.
    @(posedge clk);
    #1;
    man_d = rnd_line(); man_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1 man_v = 1'b0;
      @(negedge clk);
      check($sformatf("spur c%0d resp", c), ic_resp_valid | dc_resp_valid, 0);
      check($sformatf("spur c%0d busy", c), busy, 0);
    end

    // Random traffic with scoreboard and starvation bound.
    mem_auto = 1'b1;
    ic_done = 1'b0; dc_done = 1'b0; ic_wait = 0; dc_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      mem_req_ready = ($urandom_range(3) != 0);
      if (ic_done) begin ic_req_valid = 1'b0; ic_done = 1'b0; end
      if (dc_done) begin dc_req_valid = 1'b0; dc_done = 1'b0; end
      if (!ic_req_valid && $urandom_range(2) == 0) begin
        ic_req_addr = rnd_addr(); ic_req_valid = 1'b1; ic_wait = 0;
      end
      if (!dc_req_valid && $urandom_range(2) == 0) begin
        dc_req_we = 1'($urandom_range(1)); dc_req_addr = rnd_addr();
        dc_req_wdata = rnd_line(); dc_req_valid = 1'b1; dc_wait = 0;
      end
      @(negedge clk);
      check("rnd resp exclusive", ic_resp_valid & dc_resp_valid, 0);
      if (ic_resp_valid) begin
        check("rnd ic mem addr", acc.addr, ic_req_addr);
        check("rnd ic mem we", acc.we, 0);
        check("rnd ic data", ic_resp_data, pat(ic_req_addr));
        ic_done = 1'b1;
        if (dc_req_valid && !dc_done) begin
          dc_wait++;
          check("rnd dc starvation", dc_wait > 2, 0);
        end
      end
      if (dc_resp_valid) begin
        check("rnd dc mem addr", acc.addr, dc_req_addr);
        check("rnd dc mem we", acc.we, dc_req_we);
        if (dc_req_we) check("rnd dc mem wdata", acc.wdata, dc_req_wdata);
        else           check("rnd dc data", dc_resp_data, pat(dc_req_addr));
        dc_done = 1'b1;
        if (ic_req_valid && !ic_done) begin
          ic_wait++;
          check("rnd ic starvation", ic_wait > 2, 0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
